// File: rtl/regw_pkg.sv
// Shared types and sizing helpers for the writeback/commit stage.
package regw_pkg;

  // Default number of buffered commit records.
  localparam int REGW_DEPTH = 4;

  typedef struct packed {
    logic [63:0] pre_pc;
    logic [31:0] instr;
    logic [63:0] pc;
  } commit_rec_t;

  // Pointer width for a power-of-two FIFO.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regw_fifo.sv
// Circular FIFO of commit records. Pointers wrap modulo DEPTH (power of two).
// A write while full is accepted only if a read frees a slot in the same cycle.
module regw_fifo
  import regw_pkg::*;
#(
  parameter int DEPTH = REGW_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  commit_rec_t            din_i,
  output commit_rec_t            dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [ptr_w(DEPTH):0]  count_o
);
  localparam int PTR_W = ptr_w(DEPTH);

  commit_rec_t      mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             wr, rd;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign wr      = push_i && (!full_o || pop_i);
  assign rd      = pop_i && !empty_o;
  assign dout_o  = mem_q[head_q];
  assign count_o = count_q;

  // Occupancy: simultaneous read and write leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({wr, rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count; reset zeroes storage so head data reads 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr) begin
        mem_q[tail_q] <= din_i;
        tail_q        <= tail_q + 1'b1;
      end
      if (rd) head_q <= head_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/regw_commit.sv
// Writeback/commit stage: buffers commit records for the trace consumer,
// counts retirements, requests a front-end stall near full and flags drops.
// Optional commit watchdog built when REGW_COMMIT_WATCHDOG_EN is defined.
module regw_commit
  import regw_pkg::*;
#(
  parameter int DEPTH   = REGW_DEPTH,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regM_i_commit,
  input  logic [63:0] regM_i_commit_pre_pc,
  input  logic [31:0] regM_i_commit_instr,
  input  logic [63:0] regM_i_commit_pc,
  output logic        regW_o_commit,
  output logic [63:0] regW_o_commit_pre_pc,
  output logic [31:0] regW_o_commit_instr,
  output logic [63:0] regW_o_commit_pc,
  input  logic        regW_i_commit_ready,
  output logic        regW_o_stall,
  output logic [63:0] regW_o_retire_cnt,
  output logic        regW_o_overflow,
  output logic        regW_o_timeout
);
  localparam int PTR_W = ptr_w(DEPTH);

  // Elaboration-time guard on configuration.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_cfg
    $error("regw_commit: DEPTH must be a power of two >= 2, TIMEOUT >= 2");
  end

  commit_rec_t    din, dout;
  logic           full, empty, push, pop;
  logic [PTR_W:0] count;
  logic [63:0]    retire_q;
  logic           ovf_q;

  assign din  = '{pre_pc: regM_i_commit_pre_pc, instr: regM_i_commit_instr,
                  pc: regM_i_commit_pc};
  assign pop  = !empty && regW_i_commit_ready;
  assign push = regM_i_commit && (!full || pop);

  regw_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (regM_i_commit),
    .pop_i   (pop),
    .din_i   (din),
    .dout_o  (dout),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign regW_o_commit        = !empty;
  assign regW_o_commit_pre_pc = dout.pre_pc;
  assign regW_o_commit_instr  = dout.instr;
  assign regW_o_commit_pc     = dout.pc;
  // One slot of slack for records already in flight.
  assign regW_o_stall         = (count >= (PTR_W+1)'(DEPTH - 1));
  assign regW_o_retire_cnt    = retire_q;
  assign regW_o_overflow      = ovf_q;

  // Retire counter and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (pop) retire_q <= retire_q + 64'd1;
      if (regM_i_commit && full && !pop) ovf_q <= 1'b1;
    end
  end

`ifdef REGW_COMMIT_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  logic            wd_arm_q, wd_to_q;
  logic [WD_W-1:0] wd_cnt_q;

  // Watchdog: armed by first push, cleared by every push, counts idle-empty cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_arm_q <= 1'b0;
      wd_cnt_q <= '0;
      wd_to_q  <= 1'b0;
    end else begin
      if (push) begin
        wd_arm_q <= 1'b1;
        wd_cnt_q <= '0;
      end else if (wd_arm_q && empty && wd_cnt_q != WD_MAX) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
      if (wd_arm_q && wd_cnt_q == WD_MAX) wd_to_q <= 1'b1;
    end
  end

  assign regW_o_timeout = wd_to_q;
`else
  assign regW_o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_regw_commit.sv
// Directed bench for regw_commit (DEPTH=4, TIMEOUT=16).
module tb_regw_commit;
  import regw_pkg::*;

`ifdef REGW_COMMIT_WATCHDOG_EN
  localparam bit WD_EXP = 1'b1;
`else
  localparam bit WD_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m_commit;
  logic [63:0] m_pre_pc, m_pc;
  logic [31:0] m_instr;
  logic        w_commit, w_ready, w_stall, w_ovf, w_to;
  logic [63:0] w_pre_pc, w_pc, w_retire;
  logic [31:0] w_instr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regw_commit #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .regM_i_commit        (m_commit),
    .regM_i_commit_pre_pc (m_pre_pc),
    .regM_i_commit_instr  (m_instr),
    .regM_i_commit_pc     (m_pc),
    .regW_o_commit        (w_commit),
    .regW_o_commit_pre_pc (w_pre_pc),
    .regW_o_commit_instr  (w_instr),
    .regW_o_commit_pc     (w_pc),
    .regW_i_commit_ready  (w_ready),
    .regW_o_stall         (w_stall),
    .regW_o_retire_cnt    (w_retire),
    .regW_o_overflow      (w_ovf),
    .regW_o_timeout       (w_to)
  );

  function automatic commit_rec_t mk(input int i);
    commit_rec_t r;
    r.pre_pc = 64'h0000_0000_8000_1000 + 64'(i) * 64'd8;
    r.instr  = 32'h0000_A000 + 32'(i);
    r.pc     = r.pre_pc + 64'd4;
    return r;
  endfunction

  // Advance one edge; outputs sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input commit_rec_t r);
    m_commit = v;
    m_pre_pc = r.pre_pc;
    m_instr  = r.instr;
    m_pc     = r.pc;
  endtask

  task automatic test_reset();
    rst = 1'b0; w_ready = 1'b0; drive(1'b0, '0);
    tick(); tick();
    n_tests++;
    if ({w_commit, w_stall, w_ovf, w_to} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {w_commit, w_stall, w_ovf, w_to});
    end
    n_tests++;
    if ({w_pre_pc, w_instr, w_pc, w_retire} !== '0) begin
      n_fail++; $display("FAIL reset_data got pc=%h retire=%0d want 0", w_pc, w_retire);
    end
    rst = 1'b1;
  endtask

  task automatic test_single();
    commit_rec_t r;
    r = '{pre_pc: 64'h8000_0000, instr: 32'h0000_0013, pc: 64'h8000_0004};
    w_ready = 1'b1; drive(1'b1, r);
    tick(); drive(1'b0, '0);
    n_tests++;
    if (w_commit !== 1'b1 || {w_pre_pc, w_instr, w_pc} !== r) begin
      n_fail++; $display("FAIL single_out got v=%b pc=%h instr=%h want v=1 pc=%h", w_commit, w_pc, w_instr, r.pc);
    end
    n_tests++;
    if (w_retire !== 64'd0) begin
      n_fail++; $display("FAIL single_retire0 got %0d want 0", w_retire);
    end
    tick();
    n_tests++;
    if (w_commit !== 1'b0 || w_retire !== 64'd1) begin
      n_fail++; $display("FAIL single_retire1 got v=%b cnt=%0d want v=0 cnt=1", w_commit, w_retire);
    end
  endtask

  // Fill to full with ready low, then one more push must be dropped.
  task automatic test_fill_overflow();
    w_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, mk(i)); tick();
      n_tests++;
      if (w_stall !== (i == 3)) begin
        n_fail++; $display("FAIL fill_stall%0d got %b want %b", i, w_stall, (i == 3));
      end
    end
    drive(1'b1, mk(4)); tick();
    n_tests++;
    if (w_ovf !== 1'b0 || w_stall !== 1'b1) begin
      n_fail++; $display("FAIL full_no_ovf got ovf=%b stall=%b want 0/1", w_ovf, w_stall);
    end
    drive(1'b1, mk(5)); tick(); drive(1'b0, '0);
    n_tests++;
    if (w_ovf !== 1'b1 || {w_pre_pc, w_instr, w_pc} !== mk(1)) begin
      n_fail++; $display("FAIL overflow got ovf=%b pc=%h want 1 pc=%h", w_ovf, w_pc, mk(1).pc);
    end
  endtask

  // Push and pop on a full FIFO; drain and verify order including the new record.
  task automatic test_full_pushpop();
    commit_rec_t exp [4];
    exp = '{mk(2), mk(3), mk(4), mk(6)};
    w_ready = 1'b1; drive(1'b1, mk(6)); tick(); drive(1'b0, '0);
    n_tests++;
    if (w_stall !== 1'b1 || w_commit !== 1'b1) begin
      n_fail++; $display("FAIL pushpop_full got stall=%b v=%b want 1/1", w_stall, w_commit);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (w_commit !== 1'b1 || {w_pre_pc, w_instr, w_pc} !== exp[i]) begin
        n_fail++; $display("FAIL drain%0d got pc=%h want pc=%h", i, w_pc, exp[i].pc);
      end
      tick();
    end
    n_tests++;
    if (w_commit !== 1'b0 || w_retire !== 64'd6 || w_ovf !== 1'b1) begin
      n_fail++; $display("FAIL drain_end got v=%b cnt=%0d ovf=%b want 0/6/1", w_commit, w_retire, w_ovf);
    end
  endtask

  // Back-to-back stream with ready held high; wraps the pointers.
  task automatic test_back_to_back();
    rst = 1'b0; tick(); rst = 1'b1;
    w_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, mk(20 + i)); tick();
      n_tests++;
      if (w_commit !== 1'b1 || {w_pre_pc, w_instr, w_pc} !== mk(20 + i) || w_stall !== 1'b0) begin
        n_fail++; $display("FAIL stream%0d got pc=%h stall=%b want pc=%h", i, w_pc, w_stall, mk(20 + i).pc);
      end
    end
    drive(1'b0, '0); tick();
    n_tests++;
    if (w_commit !== 1'b0 || w_retire !== 64'd10) begin
      n_fail++; $display("FAIL stream_retire got v=%b cnt=%0d want 0/10", w_commit, w_retire);
    end
  endtask

  task automatic test_reset_mid();
    w_ready = 1'b0;
    drive(1'b1, mk(40)); tick();
    drive(1'b1, mk(41)); tick();
    rst = 1'b0; drive(1'b1, mk(42)); tick();
    rst = 1'b1; drive(1'b0, '0);
    n_tests++;
    if ({w_commit, w_stall, w_ovf, w_to} !== 4'b0000 || {w_pre_pc, w_instr, w_pc, w_retire} !== '0) begin
      n_fail++; $display("FAIL reset_mid got v=%b pc=%h cnt=%0d want all 0", w_commit, w_pc, w_retire);
    end
  endtask

  task automatic test_watchdog();
    w_ready = 1'b1;
    drive(1'b1, mk(50)); tick(); drive(1'b0, '0);
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (w_to !== 1'b0) begin
      n_fail++; $display("FAIL wd_early got %b want 0", w_to);
    end
    for (int i = 0; i < 15; i++) tick();
    n_tests++;
    if (w_to !== WD_EXP) begin
      n_fail++; $display("FAIL wd_timeout got %b want %b", w_to, WD_EXP);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_pushpop();
    test_back_to_back();
    test_reset_mid();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
